// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator and its sequencing controller.
package cic_pkg;

    localparam int DEC_WIDTH      = 4;
    localparam int MAX_DEC_FACTOR = 1 << DEC_WIDTH;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FLUSH,
        SETTLE
    } cic_ctrl_state_t;

    // Legal factors are the powers of two 1..MAX_DEC_FACTOR, i.e. one-hot values.
    function automatic logic is_legal_dec(input logic [DEC_WIDTH:0] f);
        return (f != '0)
            && ((f & (f - (DEC_WIDTH+1)'(1))) == '0)
            && (int'(f) <= MAX_DEC_FACTOR);
    endfunction

endpackage

// File: rtl/cic_phase_cnt.sv
// Decimation phase counter; mirrors the CIC's internal sample counter.
module cic_phase_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] phase,
    output logic         wrap
);

    logic last;

    assign last = (phase == modulus - W'(1));
    assign wrap = en & last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= last ? '0 : phase + W'(1);
        end
    end

endmodule

// File: rtl/cic_dec_ctrl.sv
// CIC decimator sequencing controller: frame-aligned factor changes,
// filter flush and comb-transient masking.
module cic_dec_ctrl #(
    parameter int DEC_WIDTH    = cic_pkg::DEC_WIDTH,
    parameter int Q            = 1,
    parameter int N            = 1,
    parameter int DEF_DEC      = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [DEC_WIDTH:0]   cfg_dec_factor,
    output logic                 cfg_err,
    output logic                 cfg_done,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 cic_valid_in,
    output logic                 cic_rst_n,
    output logic [DEC_WIDTH:0]   cur_dec_factor,
    input  logic                 cic_valid_out,
    input  logic                 cic_overflow,
    input  logic                 cic_underflow,
    output logic                 out_valid,
    input  logic                 status_clr,
    output logic                 ovf_sticky,
    output logic                 udf_sticky
);

    import cic_pkg::*;

    localparam int W  = DEC_WIDTH + 1;
    localparam int QN = Q * N;
    localparam int SW = $clog2(QN + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [W-1:0]  DEF_FACTOR  = W'(DEF_DEC);
    localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(QN - 1);

    cic_ctrl_state_t state;
    logic [FW-1:0]   flush_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [W-1:0]    pending;
    logic [W-1:0]    phase;
    logic            wrap;
    logic            cfg_fire;
    logic            cfg_legal;
    logic            cfg_change;
    logic            enter_flush;
    logic            unmasked;

    assign in_ready     = (state != FLUSH);
    assign cfg_ready    = (state == RUN);
    assign cic_valid_in = in_valid & in_ready;
    assign unmasked     = (state != SETTLE) && (state != FLUSH);
    assign out_valid    = cic_valid_out & unmasked;

    assign cfg_fire    = cfg_valid & cfg_ready;
    assign cfg_legal   = is_legal_dec(cfg_dec_factor);
    assign cfg_change  = cfg_fire & cfg_legal & (cfg_dec_factor != cur_dec_factor);
    assign enter_flush = ((state == RUN) && cfg_change && (phase == '0))
                      || ((state == DRAIN) && wrap);

    cic_phase_cnt #(.W(W)) u_phase (
        .clk     (clk),
        .rst     (rst),
        .en      (cic_valid_in),
        .clr     (enter_flush),
        .modulus (cur_dec_factor),
        .phase   (phase),
        .wrap    (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FLUSH;
            flush_cnt      <= '0;
            settle_cnt     <= '0;
            pending        <= DEF_FACTOR;
            cur_dec_factor <= DEF_FACTOR;
            cic_rst_n      <= 1'b0;
            cfg_err        <= 1'b0;
            cfg_done       <= 1'b0;
            ovf_sticky     <= 1'b0;
            udf_sticky     <= 1'b0;
        end else begin
            cfg_err    <= 1'b0;
            cfg_done   <= 1'b0;
            // A new flag event wins over a clear arriving in the same cycle.
            ovf_sticky <= (cic_valid_out & cic_overflow & unmasked) | (ovf_sticky & ~status_clr);
            udf_sticky <= (cic_valid_out & cic_underflow & unmasked) | (udf_sticky & ~status_clr);

            case (state)
                RUN: begin
                    if (cfg_fire) begin
                        if (!cfg_legal) begin
                            cfg_err <= 1'b1;
                        end else if (cfg_dec_factor == cur_dec_factor) begin
                            cfg_done <= 1'b1;
                        end else begin
                            pending <= cfg_dec_factor;
                            state   <= (phase == '0) ? FLUSH : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (wrap) state <= FLUSH;
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state      <= SETTLE;
                        cic_rst_n  <= 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                SETTLE: begin
                    if (cic_valid_out) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state    <= RUN;
                            cfg_done <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                end
                default: state <= FLUSH;
            endcase

            // NOTE: non-blocking assignments take the last write in the block, so this
            // flush-entry update safely overrides anything the case statement scheduled.
            if (enter_flush) begin
                flush_cnt      <= '0;
                cic_rst_n      <= 1'b0;
                cur_dec_factor <= (state == DRAIN) ? pending : cfg_dec_factor;
            end
        end
    end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed self-checking bench for cic_dec_ctrl (Q=N=1, DEF_DEC=1, FLUSH_CYCLES=2).
module tb_cic_dec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [4:0] cfg_dec_factor;
    logic       cfg_err;
    logic       cfg_done;
    logic       in_valid;
    logic       in_ready;
    logic       cic_valid_in;
    logic       cic_rst_n;
    logic [4:0] cur_dec_factor;
    logic       cic_valid_out;
    logic       cic_overflow;
    logic       cic_underflow;
    logic       out_valid;
    logic       status_clr;
    logic       ovf_sticky;
    logic       udf_sticky;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cic_dec_ctrl #(
        .DEC_WIDTH    (4),
        .Q            (1),
        .N            (1),
        .DEF_DEC      (1),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_dec_factor (cfg_dec_factor),
        .cfg_err        (cfg_err),
        .cfg_done       (cfg_done),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .cic_valid_in   (cic_valid_in),
        .cic_rst_n      (cic_rst_n),
        .cur_dec_factor (cur_dec_factor),
        .cic_valid_out  (cic_valid_out),
        .cic_overflow   (cic_overflow),
        .cic_underflow  (cic_underflow),
        .out_valid      (out_valid),
        .status_clr     (status_clr),
        .ovf_sticky     (ovf_sticky),
        .udf_sticky     (udf_sticky)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_factor(input logic [4:0] f);
        cfg_valid      = 1'b1;
        cfg_dec_factor = f;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Counts cycles with cic_rst_n low, starting from the current cycle.
    task automatic count_flush(output int n_low, output bit cur_bad, output bit rdy_bad,
                               input logic [4:0] exp_cur);
        n_low   = 0;
        cur_bad = 1'b0;
        rdy_bad = 1'b0;
        for (int i = 0; i < 10 && cic_rst_n === 1'b0; i++) begin
            n_low++;
            if (cur_dec_factor !== exp_cur) cur_bad = 1'b1;
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            tick();
        end
    endtask

    // Plays the CIC: emits an output pulse every cycle the flush is released, until cfg_done.
    task automatic wait_run(input bit with_ovf, output int pulses, output bit leaked, output bit done);
        pulses = 0;
        leaked = 1'b0;
        done   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cic_valid_out = cic_rst_n;
            cic_overflow  = with_ovf & cic_rst_n;
            #1;
            if (out_valid !== 1'b0) leaked = 1'b1;
            if (cic_valid_out) pulses++;
            tick();
            if (cfg_done === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        cic_valid_out = 1'b0;
        cic_overflow  = 1'b0;
    endtask

    task automatic test_reset();
        int n_low;
        bit cur_bad, rdy_bad;
        rst = 1'b1; cfg_valid = 1'b0; cfg_dec_factor = '0; in_valid = 1'b0;
        cic_valid_out = 1'b0; cic_overflow = 1'b0; cic_underflow = 1'b0; status_clr = 1'b0;
        repeat (3) tick();
        n_chk++; if (cic_rst_n !== 1'b0) $display("FAIL rst_cic_rst_n: got %b want 0", cic_rst_n); else n_pass++;
        n_chk++; if (cur_dec_factor !== 5'd1) $display("FAIL rst_cur: got %0d want 1", cur_dec_factor); else n_pass++;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        n_chk++; if (cfg_ready !== 1'b0) $display("FAIL rst_cfg_ready: got %b want 0", cfg_ready); else n_pass++;
        n_chk++; if ({cfg_err, cfg_done} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {cfg_err, cfg_done}); else n_pass++;
        n_chk++; if ({ovf_sticky, udf_sticky} !== 2'b00) $display("FAIL rst_sticky: got %b want 00", {ovf_sticky, udf_sticky}); else n_pass++;
        cic_valid_out = 1'b1; #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        cic_valid_out = 1'b0;
        rst = 1'b0;
        count_flush(n_low, cur_bad, rdy_bad, 5'd1);
        n_chk++; if (n_low !== 2) $display("FAIL rst_flush_len: got %0d want 2", n_low); else n_pass++;
        n_chk++; if (cur_bad || rdy_bad) $display("FAIL rst_flush_outputs: cur_bad %b rdy_bad %b want 0 0", cur_bad, rdy_bad); else n_pass++;
        n_chk++; if ({in_ready, cfg_ready} !== 2'b10) $display("FAIL rst_settle_ready: got %b want 10", {in_ready, cfg_ready}); else n_pass++;
        cic_valid_out = 1'b1; #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_settle_mask: got %b want 0", out_valid); else n_pass++;
        tick();
        cic_valid_out = 1'b0;
        n_chk++; if ({cfg_done, cfg_ready} !== 2'b11) $display("FAIL rst_done: got %b want 11", {cfg_done, cfg_ready}); else n_pass++;
        tick();
        n_chk++; if (cfg_done !== 1'b0) $display("FAIL rst_done_once: got %b want 0", cfg_done); else n_pass++;
    endtask

    task automatic test_mid_frame();
        int pulses, n_smp, n_low;
        bit leaked, done, cur_bad, rdy_bad, gate_bad;
        set_factor(5'd4);
        wait_run(1'b0, pulses, leaked, done);
        n_chk++; if (!done || cur_dec_factor !== 5'd4) $display("FAIL mid_setup: done %b cur %0d want 1 4", done, cur_dec_factor); else n_pass++;
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        set_factor(5'd8);
        n_chk++; if ({cfg_ready, in_ready, cic_rst_n} !== 3'b011) $display("FAIL mid_drain_flags: got %b want 011", {cfg_ready, in_ready, cic_rst_n}); else n_pass++;
        n_chk++; if (cur_dec_factor !== 5'd4) $display("FAIL mid_drain_cur: got %0d want 4", cur_dec_factor); else n_pass++;
        n_smp = 0;
        in_valid = 1'b1; #1;
        for (int i = 0; i < 20 && in_ready === 1'b1; i++) begin
            if (cic_valid_in === 1'b1) n_smp++;
            tick(); #1;
        end
        n_chk++; if (n_smp !== 2) $display("FAIL mid_drain_samples: got %0d want 2", n_smp); else n_pass++;
        gate_bad = (cic_valid_in !== 1'b0);
        n_chk++; if (gate_bad) $display("FAIL mid_flush_gate: got %b want 0", cic_valid_in); else n_pass++;
        count_flush(n_low, cur_bad, rdy_bad, 5'd8);
        in_valid = 1'b0;
        n_chk++; if (n_low !== 2) $display("FAIL mid_flush_len: got %0d want 2", n_low); else n_pass++;
        n_chk++; if (cur_bad || rdy_bad) $display("FAIL mid_flush_outputs: cur_bad %b rdy_bad %b want 0 0", cur_bad, rdy_bad); else n_pass++;
        wait_run(1'b0, pulses, leaked, done);
        n_chk++; if (pulses !== 1 || leaked) $display("FAIL mid_settle: pulses %0d leaked %b want 1 0", pulses, leaked); else n_pass++;
        n_chk++; if (!done || cur_dec_factor !== 5'd8) $display("FAIL mid_done: done %b cur %0d want 1 8", done, cur_dec_factor); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [4:0] bad_f [3] = '{5'd6, 5'd0, 5'd17};
        for (int k = 0; k < 3; k++) begin
            set_factor(bad_f[k]);
            n_chk++; if ({cfg_err, cfg_done} !== 2'b10) $display("FAIL illegal_%0d_pulse: got %b want 10", bad_f[k], {cfg_err, cfg_done}); else n_pass++;
            n_chk++; if (cur_dec_factor !== 5'd8) $display("FAIL illegal_%0d_cur: got %0d want 8", bad_f[k], cur_dec_factor); else n_pass++;
            n_chk++; if ({cic_rst_n, cfg_ready} !== 2'b11) $display("FAIL illegal_%0d_state: got %b want 11", bad_f[k], {cic_rst_n, cfg_ready}); else n_pass++;
            tick();
            n_chk++; if (cfg_err !== 1'b0) $display("FAIL illegal_%0d_once: got %b want 0", bad_f[k], cfg_err); else n_pass++;
        end
    endtask

    task automatic test_same_value();
        in_valid = 1'b1;
        set_factor(5'd8);
        n_chk++; if ({cfg_done, cfg_err} !== 2'b10) $display("FAIL same_pulse: got %b want 10", {cfg_done, cfg_err}); else n_pass++;
        n_chk++; if ({in_ready, cic_rst_n} !== 2'b11) $display("FAIL same_no_flush: got %b want 11", {in_ready, cic_rst_n}); else n_pass++;
        tick();
        n_chk++; if ({cfg_done, in_ready, cfg_ready} !== 3'b011) $display("FAIL same_after: got %b want 011", {cfg_done, in_ready, cfg_ready}); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_chk++; if (cur_dec_factor !== 5'd8) $display("FAIL same_cur: got %0d want 8", cur_dec_factor); else n_pass++;
    endtask

    task automatic test_reset_drain();
        int pulses, n_low;
        bit leaked, done, cur_bad, rdy_bad;
        set_factor(5'd16);
        n_chk++; if ({cfg_ready, in_ready, cic_rst_n} !== 3'b011) $display("FAIL rdrain_drain: got %b want 011", {cfg_ready, in_ready, cic_rst_n}); else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++; if (cur_dec_factor !== 5'd1) $display("FAIL rdrain_cur: got %0d want 1", cur_dec_factor); else n_pass++;
        n_chk++; if ({cic_rst_n, in_ready} !== 2'b00) $display("FAIL rdrain_flush: got %b want 00", {cic_rst_n, in_ready}); else n_pass++;
        rst = 1'b0;
        count_flush(n_low, cur_bad, rdy_bad, 5'd1);
        n_chk++; if (n_low !== 2 || cur_bad) $display("FAIL rdrain_reflush: len %0d cur_bad %b want 2 0", n_low, cur_bad); else n_pass++;
        wait_run(1'b0, pulses, leaked, done);
        n_chk++; if (!done || cur_dec_factor !== 5'd1) $display("FAIL rdrain_final: done %b cur %0d want 1 1", done, cur_dec_factor); else n_pass++;
    endtask

    task automatic test_sticky();
        int pulses;
        bit leaked, done;
        set_factor(5'd16);
        wait_run(1'b1, pulses, leaked, done);
        n_chk++; if (!done || cur_dec_factor !== 5'd16) $display("FAIL sticky_setup: done %b cur %0d want 1 16", done, cur_dec_factor); else n_pass++;
        n_chk++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_masked_ovf: got %b want 0", ovf_sticky); else n_pass++;
        cic_overflow = 1'b1;
        tick();
        n_chk++; if (ovf_sticky !== 1'b0) $display("FAIL sticky_no_valid: got %b want 0", ovf_sticky); else n_pass++;
        cic_valid_out = 1'b1; #1;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL sticky_out_valid: got %b want 1", out_valid); else n_pass++;
        tick();
        cic_valid_out = 1'b0; cic_overflow = 1'b0;
        n_chk++; if ({ovf_sticky, udf_sticky} !== 2'b10) $display("FAIL sticky_ovf_set: got %b want 10", {ovf_sticky, udf_sticky}); else n_pass++;
        status_clr = 1'b1; cic_valid_out = 1'b1; cic_underflow = 1'b1;
        tick();
        cic_valid_out = 1'b0; cic_underflow = 1'b0;
        n_chk++; if ({ovf_sticky, udf_sticky} !== 2'b01) $display("FAIL sticky_clr_vs_set: got %b want 01", {ovf_sticky, udf_sticky}); else n_pass++;
        tick();
        status_clr = 1'b0;
        n_chk++; if ({ovf_sticky, udf_sticky} !== 2'b00) $display("FAIL sticky_clr: got %b want 00", {ovf_sticky, udf_sticky}); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mid_frame();
        test_illegal();
        test_same_value();
        test_reset_drain();
        test_sticky();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cic_dec_ctrl.md
# cic_dec_ctrl

Sequencing controller for the CIC decimator. It owns the decimator's `dec_factor` and flush reset, and accepts run-time decimation changes over a valid/ready config port. A change is applied only at a decimation-frame boundary, then the filter is flushed, then the comb transient is masked before outputs are released. It sits between the upstream sample source and the CIC, gating `valid_in` and qualifying `valid_out`.

## Interface
Parameters:
- `DEC_WIDTH`, 4: log2 of max decimation (16); factor ports are DEC_WIDTH+1 bits.
- `Q`, 1: CIC order; must match the controlled CIC.
- `N`, 1: CIC differential delay; must match the controlled CIC.
- `DEF_DEC`, 1: decimation factor loaded on reset.
- `FLUSH_CYCLES`, 2: cycles `cic_rst_n` is held low per flush (≥1).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config accepted when both are high.
- `cfg_dec_factor`  in  DEC_WIDTH+1  requested factor.
- `cfg_err`  out  1  one-cycle pulse: illegal factor rejected.
- `cfg_done`  out  1  one-cycle pulse: requested factor active, outputs valid.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  controller can pass a sample.
- `cic_valid_in`  out  1  to the CIC `valid_in`.
- `cic_rst_n`  out  1  to the CIC `rst_n` (flush, active-low).
- `cur_dec_factor`  out  DEC_WIDTH+1  to the CIC `dec_factor`.
- `cic_valid_out`, `cic_overflow`, `cic_underflow`  in  1  from the CIC.
- `out_valid`  out  1  qualified CIC output valid (qualifies `cic_out`).
- `status_clr`  in  1  clears the sticky flags.
- `ovf_sticky`, `udf_sticky`  out  1  sticky saturation flags.

## Operation
- Legal factors: 1, 2, 4, 8, 16. Anything else is illegal.
- **Phase counter.** 0..cur_dec_factor-1. It increments on each `cic_valid_in` and wraps to 0. This mirrors the CIC's internal counter.
- **FSM states: RUN, DRAIN, FLUSH, SETTLE.**
- **RUN**
  - `cfg_ready`=1 and `in_ready`=1.
  - An accepted illegal factor pulses `cfg_err` next cycle. The state stays RUN and no change is made.
  - An accepted factor equal to `cur_dec_factor` pulses `cfg_done` next cycle, with no flush.
  - Any other legal factor is latched into `pending`. If phase==0, go to FLUSH; otherwise go to DRAIN.
- **DRAIN**
  - `cfg_ready`=0 and `in_ready`=1.
  - Samples continue to pass. Go to FLUSH on the cycle the phase wraps to 0.
- **FLUSH**
  - `in_ready`=0 and `cfg_ready`=0.
  - `cic_rst_n`=0 for FLUSH_CYCLES cycles.
  - `cur_dec_factor` is loaded from `pending` on FLUSH entry, and the phase is cleared.
  - Then go to SETTLE.
- **SETTLE**
  - `in_ready`=1 and `cfg_ready`=0.
  - The first Q·N `cic_valid_out` pulses are masked.
  - Go to RUN after the Q·N-th masked pulse. `cfg_done` pulses on RUN entry.
- **Gating and masking**
  - `cic_valid_in` = `in_valid & in_ready`.
  - `out_valid` = `cic_valid_out` & (state != SETTLE) & (state != FLUSH).
- **Sticky flags**
  - A flag sets on `cic_valid_out & cic_overflow` (or underflow) only when the output is unmasked.
  - `status_clr` clears both flags; a set in the same cycle wins.

## Timing
- **Reset values.** State FLUSH with the flush count at 0. `cur_dec_factor`=DEF_DEC. `cic_rst_n`=0, `in_ready`=0, `cfg_ready`=0, `cfg_err`=0, `cfg_done`=0, `out_valid`=0, both sticky flags 0, phase 0, `pending`=DEF_DEC.
- **After reset.** `cic_rst_n` stays low for FLUSH_CYCLES cycles after `rst` drops, then SETTLE, then RUN.
- **Registered vs combinational.** `cic_rst_n`, `cur_dec_factor`, state, counters, `cfg_err`, `cfg_done` and the sticky flags are registered. `in_ready`, `cfg_ready`, `cic_valid_in` and `out_valid` are combinational from registered state.
- **Config handshake.** A requester holds `cfg_valid` and `cfg_dec_factor` stable until `cfg_ready`. A request made outside RUN simply waits.
- **Reset mid-operation.** Asserting `rst` in any state discards `pending`, restores DEF_DEC and re-enters FLUSH.
- **Counter widths.** Phase is DEC_WIDTH+1 bits. The settle count is $clog2(Q·N+1) bits.

## Structure
- **Shared package `cic_pkg`:**
  - `MAX_DEC_FACTOR` and `DEC_WIDTH` constants.
  - `cic_ctrl_state_t` enum (RUN, DRAIN, FLUSH, SETTLE).
  - `is_legal_dec()` function (one-hot in the 5-bit range).
- **Sub-module.** The phase counter is one natural sub-module, `cic_phase_cnt` (enable, clear, modulus input, wrap output).

## Test plan
- **Reset.** Hold `rst` for 3 cycles, then release → `cic_rst_n`=0 for exactly 2 cycles with `cur_dec_factor`=1. With Q=N=1 the first `cic_valid_out` is masked. Then `cfg_ready`=1 and `cfg_done` pulses once.
- **Mid-frame reconfig.** With cur=4 and phase=2, accept cfg=8 → exactly 2 further samples pass (phase 3→0). Then 2 flush cycles with `cur_dec_factor`=8 and `in_ready`=0. Q·N outputs are masked, then `cfg_done` pulses.
- **Illegal requests.** cfg=6, then cfg=0, then cfg=17 → each gives a single `cfg_err` pulse. `cur_dec_factor` is unchanged and `cic_rst_n` stays 1.
- **Same-value request.** cfg=4 while cur=4 → `cfg_done` pulses the next cycle, with no flush and no gap in `in_ready`.
- **Sticky flags.** `cic_overflow` during SETTLE does not set `ovf_sticky`. An overflow in RUN sets it. `status_clr` in the same cycle as a new underflow leaves `udf_sticky`=1.
- **Reset during DRAIN.** Assert `rst` mid-DRAIN with pending=16 → `cur_dec_factor`=DEF_DEC and re-flush; 16 is never applied.
